// File: rtl/control_seq_pkg.sv
// control_seq_pkg
// Shared definitions for the microcoded control sequencer:
//   - sequencing encodings carried in each micro-word's seq field
//   - FSM state constants
//   - field-offset helpers for the micro-word layout
//     {ctrl[CTRL_W], wait[1], seq[2], next[UPC_W]} (MSB to LSB)
package control_seq_pkg;

   localparam logic [1:0] SEQ_NEXT     = 2'b00;  // upc <- upc + 1
   localparam logic [1:0] SEQ_JUMP     = 2'b01;  // upc <- next
   localparam logic [1:0] SEQ_DISPATCH = 2'b10;  // upc <- dispatch[opcode_q]
   localparam logic [1:0] SEQ_END      = 2'b11;  // instruction complete

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Total micro-word width.
   function automatic int uword_w(input int ctrl_w, input int upc_w);
      return ctrl_w + 3 + upc_w;
   endfunction

   // LSB position of the seq field.
   function automatic int seq_lsb(input int upc_w);
      return upc_w;
   endfunction

   // Bit position of the wait flag.
   function automatic int wait_bit(input int upc_w);
      return upc_w + 2;
   endfunction

   // LSB position of the control-word field.
   function automatic int ctrl_lsb(input int upc_w);
      return upc_w + 3;
   endfunction

endpackage

// File: rtl/control_seq_store.sv
// control_seq_store
// Storage for the control sequencer: micro-ROM, dispatch table and the
// dispatch valid bits, with their write ports and combinational reads.
// Ports:
//   clk, rst_n              clock, async active-low reset (clears valid bits only)
//   urom_we/addr/data       micro-ROM write port (already gated by the caller)
//   disp_we/addr/data       dispatch write port; a write also sets the valid bit
//   rd_upc -> rd_word       micro-ROM read
//   rd_opcode -> rd_disp_upc, rd_disp_valid   dispatch read
module control_seq_store
   import control_seq_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int CTRL_W   = 7,
   parameter int UPC_W    = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        urom_we,
   input  logic [UPC_W-1:0]            urom_addr,
   input  logic [CTRL_W+UPC_W+2:0]     urom_data,
   input  logic                        disp_we,
   input  logic [OPCODE_W-1:0]         disp_addr,
   input  logic [UPC_W-1:0]            disp_data,
   input  logic [UPC_W-1:0]            rd_upc,
   output logic [CTRL_W+UPC_W+2:0]     rd_word,
   input  logic [OPCODE_W-1:0]         rd_opcode,
   output logic [UPC_W-1:0]            rd_disp_upc,
   output logic                        rd_disp_valid
);

   localparam int UW    = uword_w(CTRL_W, UPC_W);
   localparam int DEPTH = 2 ** OPCODE_W;
   localparam int WORDS = 2 ** UPC_W;

   logic [UW-1:0]    urom_mem_r  [WORDS];
   logic [UPC_W-1:0] disp_mem_r  [DEPTH];
   logic [DEPTH-1:0] disp_valid_r;

   // Micro-ROM and dispatch targets: plain storage, intentionally not reset
   // so that microcode survives a reset.
   always_ff @(posedge clk) begin
      if (urom_we) begin
         urom_mem_r[urom_addr] <= urom_data;
      end
      if (disp_we) begin
         disp_mem_r[disp_addr] <= disp_data;
      end
   end

   // Dispatch valid bits: cleared by reset, set by any dispatch write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_valid_r <= {DEPTH{1'b0}};
      end else if (disp_we) begin
         disp_valid_r[disp_addr] <= 1'b1;
      end
   end

   assign rd_word       = urom_mem_r[rd_upc];
   assign rd_disp_upc   = disp_mem_r[rd_opcode];
   assign rd_disp_valid = disp_valid_r[rd_opcode];

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
// Microcoded multi-cycle control unit. Accepts one opcode at a time, walks
// the loadable micro-ROM from upc 0 and drives one control word per cycle.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   instr_valid/instr_ready/opcode  opcode handshake (sampled on accept)
//   mem_busy                        stalls micro-ops that carry the wait flag
//   ctrl, ctrl_valid                current control word and its qualifier
//   done, illegal                   one-cycle completion / trap pulses
//   urom_*, disp_*                  table write ports, honoured only in IDLE
module control_sequencer
   import control_seq_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int CTRL_W   = 7,
   parameter int UPC_W    = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        instr_valid,
   output logic                        instr_ready,
   input  logic [OPCODE_W-1:0]         opcode,
   input  logic                        mem_busy,
   output logic [CTRL_W-1:0]           ctrl,
   output logic                        ctrl_valid,
   output logic                        done,
   output logic                        illegal,
   input  logic                        urom_we,
   input  logic [UPC_W-1:0]            urom_addr,
   input  logic [CTRL_W+UPC_W+2:0]     urom_data,
   input  logic                        disp_we,
   input  logic [OPCODE_W-1:0]         disp_addr,
   input  logic [UPC_W-1:0]            disp_data
);

   localparam int UW   = uword_w(CTRL_W, UPC_W);
   localparam int C_LO = ctrl_lsb(UPC_W);
   localparam int W_B  = wait_bit(UPC_W);
   localparam int S_LO = seq_lsb(UPC_W);

   logic [0:0]          state_r, state_nxt_s;
   logic [UPC_W-1:0]    upc_r, upc_nxt_s;
   logic [OPCODE_W-1:0] opcode_r;
   logic [UW-1:0]       word_s;
   logic [UPC_W-1:0]    disp_upc_s;
   logic                disp_valid_s;
   logic                idle_s, run_s, accept_s, stall_s;
   logic                done_s, illegal_s;
   logic [1:0]          seq_s;

   assign idle_s   = (state_r == ST_IDLE);
   assign run_s    = (state_r == ST_RUN);
   // A table load in IDLE takes priority over accepting an opcode.
   assign instr_ready = idle_s && !urom_we && !disp_we;
   assign accept_s    = instr_valid && instr_ready;
   assign seq_s       = word_s[S_LO +: 2];
   assign stall_s     = run_s && word_s[W_B] && mem_busy;

   control_seq_store #(
      .OPCODE_W (OPCODE_W),
      .CTRL_W   (CTRL_W),
      .UPC_W    (UPC_W)
   ) u_store (
      .clk           (clk),
      .rst_n         (rst_n),
      .urom_we       (urom_we && idle_s),
      .urom_addr     (urom_addr),
      .urom_data     (urom_data),
      .disp_we       (disp_we && idle_s),
      .disp_addr     (disp_addr),
      .disp_data     (disp_data),
      .rd_upc        (upc_r),
      .rd_word       (word_s),
      .rd_opcode     (opcode_r),
      .rd_disp_upc   (disp_upc_s),
      .rd_disp_valid (disp_valid_s)
   );

   // Next-state / next-upc and the completion and trap pulses.
   always_comb begin
      state_nxt_s = state_r;
      upc_nxt_s   = upc_r;
      done_s      = 1'b0;
      illegal_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_RUN;
               upc_nxt_s   = {UPC_W{1'b0}};
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (stall_s) begin
               state_nxt_s = ST_RUN;
            end else begin
               case (seq_s)
                  SEQ_NEXT: begin
                     // No wrap past the last micro-ROM word: trap instead.
                     if (upc_r == {UPC_W{1'b1}}) begin
                        illegal_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                        upc_nxt_s   = {UPC_W{1'b0}};
                     end else begin
                        upc_nxt_s = upc_r + {{(UPC_W-1){1'b0}}, 1'b1};
                     end
                  end
                  SEQ_JUMP: begin
                     upc_nxt_s = word_s[UPC_W-1:0];
                  end
                  SEQ_DISPATCH: begin
                     if (disp_valid_s) begin
                        upc_nxt_s = disp_upc_s;
                     end else begin
                        illegal_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                        upc_nxt_s   = {UPC_W{1'b0}};
                     end
                  end
                  SEQ_END: begin
                     done_s      = 1'b1;
                     state_nxt_s = ST_IDLE;
                     upc_nxt_s   = {UPC_W{1'b0}};
                  end
                  default: begin
                     state_nxt_s = ST_IDLE;
                     upc_nxt_s   = {UPC_W{1'b0}};
                  end
               endcase
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            upc_nxt_s   = {UPC_W{1'b0}};
         end
      endcase
   end

   // Sequencer state, micro-PC and the latched opcode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         upc_r    <= {UPC_W{1'b0}};
         opcode_r <= {OPCODE_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         upc_r   <= upc_nxt_s;
         if (accept_s) begin
            opcode_r <= opcode;
         end
      end
   end

   assign ctrl       = run_s ? word_s[C_LO +: CTRL_W] : {CTRL_W{1'b0}};
   assign ctrl_valid = run_s;
   assign done       = done_s;
   assign illegal    = illegal_s;

endmodule
